// File: rtl/datapath_regfile_core_if.sv
// Bus bundle for datapath_regfile_core: instruction issue channel and result channel.
//   master : instruction producer / result consumer (drives in_valid, opcode/operands, out_ready)
//   slave  : the core (drives in_ready, out_valid, Result and flags)
interface datapath_regfile_core_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 8
);
    localparam int unsigned AW = $clog2(NREGS);

    // Instruction channel
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       OpCode;
    logic [AW-1:0]    Rd;
    logic [AW-1:0]    Rs1;
    logic [AW-1:0]    Rs2;
    logic [WIDTH-1:0] Imm;
    logic             UseImm;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Neg;
    logic             Carry;
    logic             Overflow;
    logic             Illegal;

    modport master (
        output in_valid, OpCode, Rd, Rs1, Rs2, Imm, UseImm, out_ready,
        input  in_ready, out_valid, Result, Zero, Neg, Carry, Overflow, Illegal
    );

    modport slave (
        input  in_valid, OpCode, Rd, Rs1, Rs2, Imm, UseImm, out_ready,
        output in_ready, out_valid, Result, Zero, Neg, Carry, Overflow, Illegal
    );
endinterface

// File: rtl/datapath_regfile_core.sv
// Single-issue register-file + ALU core with a one-deep registered result stage.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : datapath_regfile_core_if.slave (instruction in, result + flags out)
// An instruction is accepted when in_valid && in_ready; its result, flags and
// register write all land on that same edge, so the next instruction reads them.
module datapath_regfile_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    datapath_regfile_core_if.slave    bus
);
    localparam int unsigned AW  = $clog2(NREGS);
    localparam int unsigned AWS = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_ADC  = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;

    logic [WIDTH-1:0] regs_q [NREGS];

    logic             cflag_q,     cflag_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic             carry_q,     carry_d;
    logic             ovf_q,       ovf_d;
    logic             illegal_q,   illegal_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             wr_en_c;
    logic [WIDTH-1:0] op_a_c;
    logic [WIDTH-1:0] op_b_c;
    logic [AWS-1:0]   shamt_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_c_c;
    logic             alu_v_c;
    logic             alu_ill_c;

    // Handshake: a held result blocks issue unless it is being consumed this cycle
    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign wr_en_c    = accept_c && !alu_ill_c && (bus.Rd != AW'(0));

    // Operand fetch; R0 is forced to zero on read
    always_comb begin
        op_a_c = (bus.Rs1 == AW'(0)) ? '0 : regs_q[bus.Rs1];
        op_b_c = (bus.Rs2 == AW'(0)) ? '0 : regs_q[bus.Rs2];
        if (bus.UseImm) begin
            op_b_c = bus.Imm;
        end
        shamt_c = op_b_c[AWS-1:0];
    end

    // ALU: result, carry/borrow, signed overflow, illegal-op detect
    always_comb begin
        sum_c     = '0;
        alu_res_c = '0;
        alu_c_c   = 1'b0;
        alu_v_c   = 1'b0;
        alu_ill_c = 1'b0;
        unique case (bus.OpCode)
            OP_ADD, OP_ADC: begin
                sum_c = {1'b0, op_a_c} + {1'b0, op_b_c}
                      + {{WIDTH{1'b0}}, (bus.OpCode == OP_ADC) ? cflag_q : 1'b0};
                alu_res_c = sum_c[WIDTH-1:0];
                alu_c_c   = sum_c[WIDTH];
                alu_v_c   = (op_a_c[WIDTH-1] == op_b_c[WIDTH-1]) &&
                            (alu_res_c[WIDTH-1] != op_a_c[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the extended difference is the unsigned borrow
                sum_c     = {1'b0, op_a_c} - {1'b0, op_b_c};
                alu_res_c = sum_c[WIDTH-1:0];
                alu_c_c   = sum_c[WIDTH];
                alu_v_c   = (op_a_c[WIDTH-1] != op_b_c[WIDTH-1]) &&
                            (alu_res_c[WIDTH-1] != op_a_c[WIDTH-1]);
            end
            OP_AND:  alu_res_c = op_a_c & op_b_c;
            OP_OR:   alu_res_c = op_a_c | op_b_c;
            OP_XOR:  alu_res_c = op_a_c ^ op_b_c;
            OP_SLT:  alu_res_c = WIDTH'($signed(op_a_c) < $signed(op_b_c));
            OP_SLTU: alu_res_c = WIDTH'(op_a_c < op_b_c);
            OP_SLL:  alu_res_c = op_a_c << shamt_c;
            OP_SRL:  alu_res_c = op_a_c >> shamt_c;
            OP_SRA:  alu_res_c = WIDTH'($signed(op_a_c) >>> shamt_c);
            OP_MOV:  alu_res_c = op_b_c;
            default: alu_ill_c = 1'b1;
        endcase
    end

    // Next state for the result stage and carry flag
    always_comb begin
        cflag_d     = cflag_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            zero_d      = (alu_res_c == '0);
            neg_d       = alu_res_c[WIDTH-1];
            carry_d     = alu_c_c;
            ovf_d       = alu_v_c;
            illegal_d   = alu_ill_c;
            if (!alu_ill_c) begin
                cflag_d = alu_c_c;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers and register file; reset wins over acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            cflag_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                regs_q[bus.Rd] <= alu_res_c;
            end
            cflag_q     <= cflag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Neg       = neg_q;
    assign bus.Carry     = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Illegal   = illegal_q;
endmodule

// File: tb/tb_datapath_regfile_core.sv
// Self-checking bench for datapath_regfile_core (WIDTH=8, NREGS=8).
// Expected result vectors {Result, Zero, Neg, Carry, Overflow, Illegal} come from
// a reference model evaluated at acceptance, queued, and popped when the result appears.
module tb_datapath_regfile_core;
    typedef logic [12:0] exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] rm [8];
    logic       cf_m;
    exp_t       sb_q [$];

    datapath_regfile_core_if #(.WIDTH(8), .NREGS(8)) bus ();

    datapath_regfile_core #(.WIDTH(8), .NREGS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return {bus.Result, bus.Zero, bus.Neg, bus.Carry, bus.Overflow, bus.Illegal};
    endfunction

    // Reference model using integer arithmetic on both unsigned and signed views
    function automatic exp_t ref_exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic cf, output logic cf_n, output logic wr);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int sh = ub % 8;
        int r  = 0;
        int sr = 0;
        logic c = 1'b0, v = 1'b0, ill = 1'b0;
        logic [7:0] res = 8'h00;
        case (op)
            4'h0: begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128); res = 8'(r); end
            4'h1: begin r = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 127) || (sr < -128); res = 8'(r); end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = (sa < sb) ? 8'd1 : 8'd0;
            4'h6: res = 8'(ua << sh);
            4'h7: res = 8'(ua >> sh);
            4'h8: res = 8'(sa >>> sh);
            4'h9: res = (ua < ub) ? 8'd1 : 8'd0;
            4'hA: begin
                r = ua + ub + int'(cf); sr = sa + sb + int'(cf);
                c = (r > 255); v = (sr > 127) || (sr < -128); res = 8'(r);
            end
            4'hB: res = b;
            default: ill = 1'b1;
        endcase
        cf_n = ill ? cf : c;
        wr   = !ill;
        return {res, (res == 8'h00), res[7], c, v, ill};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rm[i] = 8'h00;
        cf_m = 1'b0;
        sb_q.delete();
    endtask

    // Present one instruction, wait (bounded) for acceptance, queue its expected result
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm, input logic use_imm);
        int n = 0;
        logic [7:0] a, b;
        logic cf_n, wr;
        exp_t e;
        bus.OpCode = op; bus.Rd = rd; bus.Rs1 = rs1; bus.Rs2 = rs2;
        bus.Imm = imm; bus.UseImm = use_imm; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        a = (rs1 == 3'd0) ? 8'h00 : rm[rs1];
        b = use_imm ? imm : ((rs2 == 3'd0) ? 8'h00 : rm[rs2]);
        e = ref_exec(op, a, b, cf_m, cf_n, wr);
        cf_m = cf_n;
        if (wr && rd != 3'd0) rm[rd] = e[12:5];
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.OpCode = 4'h0; bus.Rd = 3'd0; bus.Rs1 = 3'd0; bus.Rs2 = 3'd0; bus.Imm = 8'h00; bus.UseImm = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        got = obs();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (got !== 13'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 13'h0); end
    endtask

    task automatic test_add_overflow();
        exp_t got, e;
        send(4'hB, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b1);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mov_7f got=%h ov=%b exp=%h", got, bus.out_valid, e); end
        send(4'h0, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e) begin failures++; $display("FAIL add_ovf_model got=%h exp=%h", got, e); end
        checks++; if (got !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL add_ovf_const got=%h exp=%h", got, {8'h80, 5'b01010}); end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        exp_t lit [3];
        lit[0] = {8'hFF, 5'b01000};
        lit[1] = {8'h00, 5'b10100};
        lit[2] = {8'h01, 5'b00000};
        send(4'hB, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) send(4'h0, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1);
            if (i == 2) send(4'hA, 3'd3, 3'd0, 3'd0, 8'h00, 1'b1);
            e = sb_q.pop_front(); got = obs();
            checks++; if (got !== e || got !== lit[i] || bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_%0d got=%h ov=%b exp=%h", i, got, bus.out_valid, lit[i]);
            end
        end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        exp_t got, e, held;
        logic cf_n, wr;
        send(4'hB, 3'd1, 3'd0, 3'd0, 8'h33, 1'b1);
        held = sb_q.pop_front();
        bus.out_ready = 1'b0;
        bus.OpCode = 4'h0; bus.Rd = 3'd2; bus.Rs1 = 3'd1; bus.Rs2 = 3'd0; bus.Imm = 8'h01; bus.UseImm = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = obs();
            checks++; if (bus.in_ready !== 1'b0 || got !== held) begin
                failures++; $display("FAIL stall_%0d in_ready=%b got=%h exp=%h", i, bus.in_ready, got, held);
            end
        end
        bus.out_ready = 1'b1;
        e = ref_exec(4'h0, rm[1], 8'h01, cf_m, cf_n, wr);
        cf_m = cf_n; rm[2] = e[12:5];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = obs();
        checks++; if (got !== e || got[12:5] !== 8'h34 || bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_release got=%h ov=%b exp=%h", got, bus.out_valid, e);
        end
    endtask

    task automatic test_ops();
        exp_t got, e;
        logic [7:0] lit [4];
        logic [3:0] ops [4];
        logic [2:0] s1 [4];
        logic [2:0] s2 [4];
        lit[0] = 8'hF0; ops[0] = 4'h8; s1[0] = 3'd1; s2[0] = 3'd4;
        lit[1] = 8'h10; ops[1] = 4'h7; s1[1] = 3'd1; s2[1] = 3'd4;
        lit[2] = 8'h01; ops[2] = 4'h5; s1[2] = 3'd2; s2[2] = 3'd3;
        lit[3] = 8'h00; ops[3] = 4'h9; s1[3] = 3'd2; s2[3] = 3'd3;
        send(4'hB, 3'd1, 3'd0, 3'd0, 8'h80, 1'b1);
        send(4'hB, 3'd2, 3'd0, 3'd0, 8'hFF, 1'b1);
        send(4'hB, 3'd3, 3'd0, 3'd0, 8'h01, 1'b1);
        send(4'hB, 3'd4, 3'd0, 3'd0, 8'h03, 1'b1);
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(ops[i], 3'd5, s1[i], s2[i], 8'h00, 1'b0);
            e = sb_q.pop_front(); got = obs();
            checks++; if (got !== e || got[12:5] !== lit[i]) begin
                failures++; $display("FAIL op_%h got=%h exp=%h lit=%h", ops[i], got, e, lit[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            e = sb_q.pop_front(); got = obs();
            checks++; if (got !== e) begin failures++; $display("FAIL rand_%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_r0_illegal();
        exp_t got, e;
        send(4'hB, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1);
        void'(sb_q.pop_front());
        send(4'h0, 3'd5, 3'd0, 3'd0, 8'h00, 1'b1);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || got[12:5] !== 8'h00) begin failures++; $display("FAIL r0_read got=%h exp=%h", got, e); end
        send(4'hB, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b1);
        send(4'h0, 3'd6, 3'd1, 3'd0, 8'h01, 1'b1);
        send(4'hF, 3'd6, 3'd1, 3'd1, 8'h77, 1'b1);
        void'(sb_q.pop_front()); void'(sb_q.pop_front());
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || got !== {8'h00, 5'b10001}) begin failures++; $display("FAIL illegal got=%h exp=%h", got, {8'h00, 5'b10001}); end
        send(4'hA, 3'd7, 3'd0, 3'd0, 8'h00, 1'b1);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || got[12:5] !== 8'h01) begin failures++; $display("FAIL adc_after_illegal got=%h exp=%h", got, e); end
        send(4'hB, 3'd0, 3'd0, 3'd6, 8'h00, 1'b0);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || got[12:5] !== 8'h00) begin failures++; $display("FAIL illegal_no_write got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        bus.out_ready = 1'b0;
        send(4'hB, 3'd4, 3'd0, 3'd0, 8'h44, 1'b1);
        sb_q.delete();
        bus.OpCode = 4'hB; bus.Rd = 3'd5; bus.Imm = 8'h99; bus.UseImm = 1'b1; bus.in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.in_valid = 1'b0;
        model_reset();
        got = obs();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== 13'h0) begin
            failures++; $display("FAIL reset_mid ov=%b in_ready=%b got=%h exp ov=0 rdy=1 out=0", bus.out_valid, bus.in_ready, got);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            send(4'hB, 3'd0, 3'd0, 3'(k), 8'hAA, 1'b0);
            e = sb_q.pop_front(); got = obs();
            checks++; if (got !== e || got[12:5] !== 8'h00) begin failures++; $display("FAIL reset_reg_%0d got=%h exp=%h", k, got, e); end
        end
        send(4'hA, 3'd1, 3'd0, 3'd0, 8'h00, 1'b1);
        e = sb_q.pop_front(); got = obs();
        checks++; if (got !== e || got[12:5] !== 8'h00) begin failures++; $display("FAIL reset_cflag got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_backpressure();
        test_ops();
        test_r0_illegal();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_regfile_core.md
DATAPATH_REGFILE_CORE -- requirements
Module: datapath_regfile_core

Interface
REQ-001 Parameter WIDTH, default 8, data width; legal values 8, 16, 32.
REQ-002 Parameter NREGS, default 8, register count; power of two, 2..32; AW = $clog2(NREGS).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  instruction present.
REQ-006 in_ready  out  1  core can accept an instruction.
REQ-007 OpCode  in  4  operation select.
REQ-008 Rd, Rs1, Rs2  in  AW each  destination and source register indices.
REQ-009 Imm  in  WIDTH  immediate operand.
REQ-010 UseImm  in  1  1: operand B = Imm, 0: operand B = R[Rs2].
REQ-011 out_valid  out  1  registered result pending.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 Result  out  WIDTH  registered result.
REQ-014 Zero, Neg, Carry, Overflow  out  1 each  registered flags of the result held in Result.
REQ-015 Illegal  out  1  registered; held result came from an unsupported OpCode.

Function
REQ-016 Operand A SHALL be R[Rs1], and operand B SHALL be Imm or R[Rs2]. R0 SHALL always read 0.
REQ-017 OpCodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 ADC (A+B+Cflag), 1011 MOV (Result=B).
REQ-018 SLT and SLTU SHALL return 1 when true, else 0, zero-extended to WIDTH.
REQ-019 Shift amount SHALL be B[AWS-1:0], where AWS = $clog2(WIDTH). SRA SHALL fill with A[WIDTH-1].
REQ-020 ADD and ADC Carry SHALL be bit WIDTH of the WIDTH+1-bit unsigned sum.
REQ-021 ADD and ADC Overflow SHALL be 1 when A and B have equal signs and the result sign differs from them.
REQ-022 SUB Carry SHALL be 1 on unsigned borrow (A<B).
REQ-023 SUB Overflow SHALL be 1 when A and B have different signs and the result sign differs from A.
REQ-024 All other ops SHALL set Carry=0 and Overflow=0.
REQ-025 Zero SHALL be (result==0), and Neg SHALL be result[WIDTH-1], for every op.
REQ-026 OpCodes 1100-1111 SHALL produce Result=0, Zero=1, Neg=0, Carry=0, Overflow=0, Illegal=1, with no register write and no Cflag update.
REQ-027 in_ready SHALL equal !out_valid || out_ready, combinationally. This is the only combinational input-to-output path.
REQ-028 An instruction SHALL be accepted on an edge where in_valid && in_ready.
REQ-029 On acceptance, the core SHALL in the same edge: load Result and flags, set out_valid=1, write R[Rd] (suppressed when Rd==0), and update internal Cflag from Carry.
REQ-030 Latency SHALL be 1 cycle: the result is visible the cycle after acceptance.
REQ-031 The core SHALL sustain 1 instruction per cycle while out_ready=1.
REQ-032 A dependent instruction issued the very next cycle SHALL see the written value and the updated Cflag; no stall or forwarding is needed.
REQ-033 out_valid SHALL clear on an edge with out_ready=1 and no acceptance. It SHALL stay 1 when acceptance and consumption coincide, with the new result replacing the old.
REQ-034 While out_valid=1 and out_ready=0, Result, flags and Illegal SHALL hold stable, in_ready SHALL be 0, and no register or Cflag change SHALL occur.
REQ-035 Inputs SHALL be ignored when in_valid=0. No state SHALL change except the out_valid clear of REQ-033.
REQ-036 Register write to Rd and read of the same index on the same edge SHALL return the old value to the current instruction.

Reset
REQ-037 On a clk edge with rst_n=0, all registers, Cflag, out_valid, Result, Zero, Neg, Carry, Overflow and Illegal SHALL become 0.
REQ-038 Reset SHALL dominate acceptance. An instruction presented during reset SHALL be discarded, and a pending result SHALL be lost.
REQ-039 in_ready SHALL be 1 in the first cycle after reset deassertion.

Verification (WIDTH=8, NREGS=8)
REQ-040 MOV R1=0x7F then ADD R2=R1+Imm 0x01, out_ready=1 -> Result 0x80, Neg=1, Overflow=1, Carry=0, one cycle after each accept.
REQ-041 MOV R1=0xFF, ADD R2=R1+Imm 0x01, then ADC R3=R0+Imm 0x00 back-to-back -> Results 0x00 (Zero=1, Carry=1), then 0x01.
REQ-042 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, Result stable; the first edge after out_ready=1 accepts the next instruction.
REQ-043 SRA 0x80 by 3 -> 0xF0. SRL 0x80 by 3 -> 0x10. SLT 0xFF,0x01 -> 1. SLTU 0xFF,0x01 -> 0.
REQ-044 Write to R0, then read R0 -> 0. OpCode 1111 -> Illegal=1, Result=0, and a following ADC sees Cflag unchanged.
REQ-045 rst_n=0 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, all registers read 0, in_ready=1.
